// File: rtl/pmod_ui_pkg.sv
// Shared constants, classifier state encoding and event type for the PMOD UI controller.
package pmod_ui_pkg;

  localparam int unsigned BTN_N = 3;
  localparam int unsigned LED_N = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  typedef struct packed {
    logic [1:0] btn;
    logic       is_long;
  } evt_t;

  // Modulo-3 add for button indices; both operands are in 0..2.
  function automatic logic [1:0] rr_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/pmod_ui_ctrl_if.sv
// Button event channel: valid/ready handshake carrying button index and long flag.
interface pmod_ui_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic       evt_long;

  modport master (output evt_valid, output evt_btn, output evt_long, input evt_ready);
  modport slave  (input evt_valid, input evt_btn, input evt_long, output evt_ready);
endinterface

// File: rtl/pmod_btn_press.sv
// Per-button short/long press classifier: edge flop, hold counter and IDLE/HELD/LONG FSM.
module pmod_btn_press
  import pmod_ui_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev_stb,
  output logic ev_long
);

  localparam int unsigned    CW       = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LONG_CYCLES - 1);

  logic          btn_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ev_stb  = 1'b0;
    ev_long = 1'b0;
    case (st_q)
      ST_IDLE: begin
        // The edge cycle already counts as held, so the long event fires
        // in the LONG_CYCLES-th consecutive pressed cycle.
        if (btn && !btn_q) begin
          st_d  = ST_HELD;
          cnt_d = CW'(1);
        end
      end
      ST_HELD: begin
        if (!btn) begin
          ev_stb = 1'b1;
          st_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ev_stb  = 1'b1;
          ev_long = 1'b1;
          st_d    = ST_LONG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LONG: begin
        if (!btn) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b1;
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      btn_q <= btn;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmod_ui_ctrl.sv
// PMOD user-interface controller: press classification, round-robin event channel,
// sticky overflow flags and pattern/blink LED drive.
module pmod_ui_ctrl
  import pmod_ui_pkg::*;
#(
  parameter int unsigned LONG_CYCLES  = 12000000,
  parameter int unsigned BLINK_CYCLES = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_N-1:0] btns,
  output logic [LED_N-1:0] leds,
  input  logic             cfg_we,
  input  logic [LED_N-1:0] cfg_pattern,
  input  logic [LED_N-1:0] cfg_blink,
  pmod_ui_ctrl_if.master   evt,
  output logic [BTN_N-1:0] ovf,
  input  logic             ovf_clr
);

  localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BTN_N-1:0] stb, stb_long;
  logic [BTN_N-1:0] pend_q, pend_d, pend_long_q, pend_long_d;
  logic [BTN_N-1:0] gnt, new_ovf, keep_new, ovf_q, ovf_d;
  logic [1:0]       rr_q, rr_d, cand, gnt_idx;
  logic             gnt_any, load;
  logic             valid_q, valid_d;
  evt_t             out_q, out_d;
  logic [LED_N-1:0] pat_q, blk_q, leds_q, leds_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             ph_q, ph_d;

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    pmod_btn_press #(.LONG_CYCLES(LONG_CYCLES)) u_press (
      .clk     (clk),
      .rst     (rst),
      .btn     (btns[i]),
      .ev_stb  (stb[i]),
      .ev_long (stb_long[i])
    );
  end

  always_comb begin
    load    = !valid_q || evt.evt_ready;
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int unsigned k = 0; k < BTN_N; k++) begin
      cand = rr_add(rr_q, 2'(k));
      if (!gnt_any && pend_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end

    gnt     = '0;
    rr_d    = rr_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (load) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        gnt[gnt_idx]  = 1'b1;
        rr_d          = rr_add(gnt_idx, 2'd1);
        out_d.btn     = gnt_idx;
        out_d.is_long = pend_long_q[gnt_idx];
      end
    end

    // A slot being granted this cycle is free for a same-cycle new event.
    new_ovf     = stb & pend_q & ~gnt;
    keep_new    = stb & ~new_ovf;
    pend_d      = (pend_q & ~gnt) | stb;
    pend_long_d = (keep_new & stb_long) | (~keep_new & pend_long_q);
    ovf_d       = (ovf_clr ? '0 : ovf_q) | new_ovf;
  end

  always_comb begin
    bcnt_d = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
    ph_d   = ph_q ^ (bcnt_q == BLINK_LAST);
    leds_d = pat_q ^ (blk_q & {LED_N{ph_q}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      rr_q        <= '0;
      valid_q     <= 1'b0;
      out_q       <= '0;
      ovf_q       <= '0;
      pat_q       <= '0;
      blk_q       <= '0;
      leds_q      <= '0;
      bcnt_q      <= '0;
      ph_q        <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      leds_q      <= leds_d;
      bcnt_q      <= bcnt_d;
      ph_q        <= ph_d;
      if (cfg_we) begin
        pat_q <= cfg_pattern;
        blk_q <= cfg_blink;
      end
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_btn   = out_q.btn;
  assign evt.evt_long  = out_q.is_long;
  assign ovf           = ovf_q;
  assign leds          = leds_q;

endmodule
